// File: rtl/sp_ram_master.sv
// Controller for a single-port synchronous RAM. It accepts single read/write
// commands on a valid/ready port, returns read data on a valid/ready response
// port, and has a fill engine that writes one value to every RAM location.
module sp_ram_master #(
  parameter int addr_width = 6,
  parameter int data_width = 8,
  parameter int depth      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [data_width-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_rdata,
  output logic [addr_width-1:0] rsp_addr,
  input  logic                  fill_start,
  input  logic [data_width-1:0] fill_value,
  output logic                  fill_done,
  output logic                  busy,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_data,
  output logic                  ram_we,
  input  logic [data_width-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP,
    FILL
  } state_t;

  // The fill engine stops on this address, so non-power-of-two depths never
  // step ram_addr past the last real word.
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);

  state_t                r_state;
  state_t                w_nextState;
  logic [addr_width-1:0] r_ramAddr,   w_ramAddrNext;
  logic [data_width-1:0] r_ramData,   w_ramDataNext;
  logic                  r_ramWe,     w_ramWeNext;
  logic                  r_rspValid,  w_rspValidNext;
  logic [data_width-1:0] r_rspRdata,  w_rspRdataNext;
  logic [addr_width-1:0] r_rspAddr,   w_rspAddrNext;
  logic                  r_fillDone,  w_fillDoneNext;

  // State register; reset abandons any command or fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and next-output logic. ram_addr doubles as the fill counter,
  // and ram_we left over from acceptance tells ISSUE whether it is a write.
  always_comb begin
    w_nextState    = r_state;
    w_ramAddrNext  = r_ramAddr;
    w_ramDataNext  = r_ramData;
    w_ramWeNext    = r_ramWe;
    w_rspValidNext = r_rspValid;
    w_rspRdataNext = r_rspRdata;
    w_rspAddrNext  = r_rspAddr;
    w_fillDoneNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (fill_start) begin
          w_nextState   = FILL;
          w_ramAddrNext = '0;
          w_ramDataNext = fill_value;
          w_ramWeNext   = 1'b1;
        end else if (cmd_valid) begin
          w_nextState   = ISSUE;
          w_ramAddrNext = cmd_addr;
          w_ramDataNext = cmd_wdata;
          w_ramWeNext   = cmd_we;
          w_rspAddrNext = cmd_addr;
        end
      end
      ISSUE: begin
        if (r_ramWe) begin
          w_ramWeNext = 1'b0;
          w_nextState = IDLE;
        end else begin
          w_nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        w_rspRdataNext = ram_q;
        w_rspValidNext = 1'b1;
        w_nextState    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_rspValidNext = 1'b0;
          w_nextState    = IDLE;
        end
      end
      FILL: begin
        if (r_ramAddr == LAST_ADDR) begin
          w_ramWeNext    = 1'b0;
          w_fillDoneNext = 1'b1;
          w_nextState    = IDLE;
        end else begin
          w_ramAddrNext = r_ramAddr + addr_width'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Registered RAM pins, response and fill-done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ramAddr  <= '0;
      r_ramData  <= '0;
      r_ramWe    <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspAddr  <= '0;
      r_fillDone <= 1'b0;
    end else begin
      r_ramAddr  <= w_ramAddrNext;
      r_ramData  <= w_ramDataNext;
      r_ramWe    <= w_ramWeNext;
      r_rspValid <= w_rspValidNext;
      r_rspRdata <= w_rspRdataNext;
      r_rspAddr  <= w_rspAddrNext;
      r_fillDone <= w_fillDoneNext;
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = ~cmd_ready;
  assign ram_addr  = r_ramAddr;
  assign ram_data  = r_ramData;
  assign ram_we    = r_ramWe;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_addr  = r_rspAddr;
  assign fill_done = r_fillDone;

endmodule

// File: tb/tb_sp_ram_master.sv
// Bench for sp_ram_master: a depth-64 instance attached to a model of the
// single-port synchronous RAM, plus a depth-40 instance used for fills only.
module tb_sp_ram_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_we, rsp_ready, fill_start;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata, fill_value;
  logic       cmd_ready, rsp_valid, fill_done, busy, ram_we;
  logic [7:0] rsp_rdata, ram_data, ram_q;
  logic [5:0] rsp_addr, ram_addr;

  // Depth-40 instance: only its fill engine is exercised.
  logic       f40Start;
  logic [7:0] f40Value;
  logic       f40Ready, f40RspValid, f40Done, f40Busy, f40We;
  logic [7:0] f40RspRdata, f40Data;
  logic [5:0] f40RspAddr, f40Addr;

  // RAM model and reference memory contents.
  logic [7:0] mem [0:63];
  logic [5:0] rdAddr;
  logic [7:0] refMem [0:63];

  int assertCount = 0;
  int failCount   = 0;
  int f40Writes   = 0;
  int f40Dones    = 0;
  int f40MaxAddr  = 0;

  always #5 clk = ~clk;

  sp_ram_master #(.addr_width(6), .data_width(8), .depth(64)) u64 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_addr(rsp_addr),
    .fill_start(fill_start), .fill_value(fill_value), .fill_done(fill_done),
    .busy(busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  sp_ram_master #(.addr_width(6), .data_width(8), .depth(40)) u40 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(1'b0), .cmd_ready(f40Ready), .cmd_we(1'b0),
    .cmd_addr(6'd0), .cmd_wdata(8'd0),
    .rsp_valid(f40RspValid), .rsp_ready(1'b1), .rsp_rdata(f40RspRdata),
    .rsp_addr(f40RspAddr),
    .fill_start(f40Start), .fill_value(f40Value), .fill_done(f40Done),
    .busy(f40Busy),
    .ram_addr(f40Addr), .ram_data(f40Data), .ram_we(f40We), .ram_q(8'd0)
  );

  // Single-port RAM: write when we=1, otherwise register the read address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else        rdAddr <= ram_addr;
  end
  assign ram_q = mem[rdAddr];

  // Observe every write and done pulse of the depth-40 instance.
  always @(posedge clk) begin
    if (f40We) begin
      f40Writes <= f40Writes + 1;
      if (int'(f40Addr) > f40MaxAddr) f40MaxAddr <= int'(f40Addr);
    end
    if (f40Done) f40Dones <= f40Dones + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    checkOutput("readyTimeout", cmd_ready, 1);
  endtask

  // One command; reads hold rsp_ready low for rspDelay cycles of RESP.
  task automatic applyStimulus(input logic we, input logic [5:0] addr,
                               input logic [7:0] data, input int rspDelay);
    logic [7:0] expData;
    waitReady();
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = data;
    rsp_ready = (rspDelay == 0);
    tick();
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = 6'($urandom);
    cmd_wdata = 8'($urandom);
    if (we) begin
      checkOutput("wrWe", ram_we, 1);
      checkOutput("wrAddr", ram_addr, addr);
      checkOutput("wrData", ram_data, data);
      checkOutput("wrBusy", cmd_ready, 0);
      tick();
      checkOutput("wrWeOff", ram_we, 0);
      checkOutput("wrReadyBack", cmd_ready, 1);
      refMem[addr] = data;
    end else begin
      expData = refMem[addr];
      checkOutput("rdWe", ram_we, 0);
      checkOutput("rdBusyE0", cmd_ready, 0);
      checkOutput("rdValidE0", rsp_valid, 0);
      tick();
      checkOutput("rdBusyE1", cmd_ready, 0);
      checkOutput("rdValidE1", rsp_valid, 0);
      tick();
      checkOutput("rdValidE2", rsp_valid, 1);
      checkOutput("rdData", rsp_rdata, expData);
      checkOutput("rdAddr", rsp_addr, addr);
      checkOutput("rdBusyE2", cmd_ready, 0);
      for (int k = 0; k < rspDelay; k++) begin
        tick();
        checkOutput("holdValid", rsp_valid, 1);
        checkOutput("holdData", rsp_rdata, expData);
        checkOutput("holdAddr", rsp_addr, addr);
        checkOutput("holdNoWrite", ram_we, 0);
        checkOutput("holdBusy", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      checkOutput("rspReleased", rsp_valid, 0);
      checkOutput("rdReadyBack", cmd_ready, 1);
      rsp_ready = 1'b0;
    end
  endtask

  // Full fill of the depth-64 instance, optionally colliding with a write.
  task automatic runFill(input logic [7:0] v, input logic collide);
    waitReady();
    fill_start = 1'b1;
    fill_value = v;
    if (collide) begin
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 6'd2;
      cmd_wdata = 8'h11;
    end
    tick();
    fill_start = 1'b0;
    fill_value = 8'($urandom);
    for (int i = 0; i < 64; i++) begin
      checkOutput("fillWe", ram_we, 1);
      checkOutput("fillAddr", ram_addr, i);
      checkOutput("fillData", ram_data, v);
      checkOutput("fillDoneEarly", fill_done, 0);
      checkOutput("fillBusy", busy, 1);
      tick();
    end
    checkOutput("fillDone", fill_done, 1);
    checkOutput("fillWeOff", ram_we, 0);
    checkOutput("fillIdle", cmd_ready, 1);
    for (int a = 0; a < 64; a++) refMem[a] = v;
    tick();
    checkOutput("fillDonePulse", fill_done, 0);
    if (collide) begin
      checkOutput("colWe", ram_we, 1);
      checkOutput("colAddr", ram_addr, 2);
      checkOutput("colData", ram_data, 8'h11);
      cmd_valid = 1'b0;
      tick();
      checkOutput("colWeOff", ram_we, 0);
      checkOutput("colReady", cmd_ready, 1);
      refMem[2] = 8'h11;
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    fill_start = 1'b0;
    fill_value = '0;
    f40Start   = 1'b0;
    f40Value   = '0;

    // Asynchronous reset between edges.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rstAddr", ram_addr, 0);
    checkOutput("rstData", ram_data, 0);
    checkOutput("rstWe", ram_we, 0);
    checkOutput("rstValid", rsp_valid, 0);
    checkOutput("rstRdata", rsp_rdata, 0);
    checkOutput("rstRspAddr", rsp_addr, 0);
    checkOutput("rstDone", fill_done, 0);
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    checkOutput("idleReady", cmd_ready, 1);
    checkOutput("idleBusy", busy, 0);

    // Known contents first, then directed write/read and backpressure.
    runFill(8'($urandom), 1'b0);
    applyStimulus(1'b1, 6'd5, 8'hA5, 0);
    applyStimulus(1'b0, 6'd5, 8'h00, 0);
    applyStimulus(1'b1, 6'd9, 8'h3C, 0);
    applyStimulus(1'b0, 6'd9, 8'h00, 5);

    // Fill with 0x77 and read back the ends and the middle.
    runFill(8'h77, 1'b0);
    applyStimulus(1'b0, 6'd0, 8'h00, 0);
    applyStimulus(1'b0, 6'd31, 8'h00, 1);
    applyStimulus(1'b0, 6'd63, 8'h00, 0);

    // Fill colliding with a write to address 2.
    runFill(8'($urandom), 1'b1);
    applyStimulus(1'b0, 6'd2, 8'h00, 0);

    // Random traffic against the reference memory.
    for (int t = 0; t < 60; t++) begin
      applyStimulus(1'($urandom), 6'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)));
    end

    // Fill aborted by reset at address 20.
    fill_start = 1'b1;
    fill_value = 8'hC3;
    tick();
    fill_start = 1'b0;
    n = 0;
    while (ram_addr != 6'd20 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("abortReached", ram_addr, 20);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abortWe", ram_we, 0);
    checkOutput("abortAddr", ram_addr, 0);
    checkOutput("abortDone", fill_done, 0);
    checkOutput("abortBusy", busy, 0);
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("postAbortDone", fill_done, 0);
      checkOutput("postAbortWe", ram_we, 0);
      checkOutput("postAbortIdle", cmd_ready, 1);
    end

    // Depth-40 fill: 40 writes, last address 39, one done pulse.
    @(negedge clk);
    f40Start = 1'b1;
    f40Value = 8'h5A;
    tick();
    f40Start = 1'b0;
    checkOutput("f40Busy", f40Ready, 0);
    n = 0;
    while (!f40Done && n < 100) begin
      tick();
      n++;
    end
    checkOutput("f40Cycles", n, 40);
    checkOutput("f40LastAddr", f40Addr, 39);
    checkOutput("f40WeOff", f40We, 0);
    tick();
    checkOutput("f40Writes", f40Writes, 40);
    checkOutput("f40MaxAddr", f40MaxAddr, 39);
    checkOutput("f40Dones", f40Dones, 1);
    checkOutput("f40Idle", f40Ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sp_ram_master.md
Name: sp_ram_master

Overview:
- Initiator/controller for the team's single-port synchronous RAM: drives its address, write-data and write-enable pins and captures its read data.
- Gives upstream logic a valid/ready command port for single reads and writes, a valid/ready response port for read data, and a hardware fill engine that writes one value to every location.
- Sits between a datapath or CPU-side requester and one RAM instance.

Parameters:
- addr_width, 6, RAM address width in bits
- data_width, 8, RAM word width in bits
- depth, 64, number of RAM words; 2 <= depth <= 2**addr_width; need not be a power of two

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_we  input  1  1 = write, 0 = read
- cmd_addr  input  addr_width  command address
- cmd_wdata  input  data_width  write data
- rsp_valid  output  1  read response present
- rsp_ready  input  1  consumer accepts the response
- rsp_rdata  output  data_width  read data
- rsp_addr  output  addr_width  address the read data came from
- fill_start  input  1  request a full-memory fill; sampled only in IDLE
- fill_value  input  data_width  fill pattern; latched on fill_start
- fill_done  output  1  one-cycle pulse when a fill completes
- busy  output  1  high in any state other than IDLE
- ram_addr  output  addr_width  to RAM addr
- ram_data  output  data_width  to RAM data
- ram_we  output  1  to RAM we
- ram_q  input  data_width  from RAM q; q shows the word at the address registered on the last edge with we=0

Behaviour:
- **Reset.** rst_n low, asynchronous, may assert at any cycle including mid-operation.
  - State goes to IDLE.
  - ram_addr, ram_data, ram_we, rsp_valid, rsp_rdata, rsp_addr, fill_done and the fill counter all go to 0.
  - Any in-flight command or fill is abandoned; RAM contents are then unspecified.
- **Registered outputs.** ram_addr, ram_data, ram_we, rsp_* and fill_done are registered. cmd_ready = (state==IDLE). busy = !cmd_ready.
- **States.** IDLE, ISSUE, CAPTURE, RESP, FILL.
- **IDLE:**
  - fill_start=1 takes priority over cmd_valid.
    - go to FILL; ram_addr<=0; ram_data<=fill_value; ram_we<=1.
  - Else cmd_valid=1 accepts the command.
    - ram_addr<=cmd_addr; ram_data<=cmd_wdata; ram_we<=cmd_we; rsp_addr<=cmd_addr.
    - go to ISSUE.
- **ISSUE** (RAM samples its pins on the exiting edge):
  - write command: ram_we<=0; go to IDLE.
  - read command: go to CAPTURE.
- **CAPTURE:** ram_q is valid. rsp_rdata<=ram_q; rsp_valid<=1; go to RESP.
- **RESP:** rsp_valid, rsp_rdata and rsp_addr are held stable until rsp_ready=1. On that edge rsp_valid<=0 and go to IDLE.
- **Throughput and latency.** The accepting edge is E0.
  - Write: RAM write occurs at E1; cmd_ready high again after E1; one write every 2 cycles.
  - Read: rsp_valid first high after E2. With rsp_ready tied high, one read every 3 cycles.
- **Protocol rules.**
  - Commands are never accepted while cmd_ready=0; cmd_* may change freely then.
  - fill_start outside IDLE is ignored, not queued.
- **FILL:**
  - On each edge: if ram_addr==depth-1 then ram_we<=0, fill_done<=1, go to IDLE; otherwise ram_addr<=ram_addr+1.
  - Writes therefore land at E1..E_depth for addresses 0..depth-1, exactly depth writes.
  - fill_done is high for exactly the one cycle after E_depth; otherwise it is 0.
- **Width rules.** ram_addr never exceeds depth-1 during a fill. cmd_addr >= depth is passed through unchanged; the RAM decides what happens.
- **Simultaneous events.** cmd_valid together with fill_start in IDLE: the fill wins, the command is not accepted, and cmd_valid must be held until cmd_ready returns.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all registered outputs 0 immediately; after release, cmd_ready=1, busy=0.
- Write then read: write addr 5 data 0xA5; then read addr 5 with rsp_ready=1 -> rsp_valid high exactly 2 cycles after read acceptance, rsp_rdata=0xA5, rsp_addr=5, cmd_ready=0 for 3 cycles.
- Backpressure: read addr 9 (previously written 0x3C) with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=0x3C stay stable, cmd_ready=0, no further RAM writes; accepted on the first rsp_ready=1 cycle.
- Fill: fill_start with fill_value=0x77 (depth 64) -> 64 consecutive ram_we cycles on addresses 0..63, a single fill_done pulse, then reads of addr 0, 31 and 63 return 0x77.
- Collision and reset mid-fill: fill_start together with cmd_valid (write addr 2 data 0x11) -> fill runs first, then the write is accepted; read addr 2 = 0x11. A separate fill aborted by rst_n at address 20 -> ram_we=0 at once, no fill_done, IDLE after release.
- Non-power-of-two: depth=40, addr_width=6 -> fill ends at address 39 after 40 writes; ram_addr never reaches 40.
